weight_fetch_ctrl: RTL and testbench

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

---
 rtl/weight_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: streams numWeight words from the weight memory,
// through a 2-entry skid FIFO, to the neuron datapath.
module weight_fetch_ctrl #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addressWidth:0] base_addr,
    output logic                  mem_ren,
    output logic [addressWidth:0] mem_raddr,
    input  logic [dataWidth-1:0]  mem_rdata,
    output logic [dataWidth-1:0]  w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done
);
    // state | meaning
    // IDLE  | waiting for start
    // FETCH | issuing memory reads
    // DRAIN | all reads issued, delivering the remaining words
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int            CW       = addressWidth + 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(numWeight - 1);

    logic [1:0]            state;
    logic [addressWidth:0] base_q;
    logic [addressWidth:0] last_addr;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         xfer_cnt;
    logic [dataWidth-1:0]  q0;
    logic [dataWidth-1:0]  q1;
    logic [1:0]            fill;
    logic                  pend;
    logic [1:0]            held;
    logic [dataWidth-1:0]  head;
    logic                  pop;
    logic                  last_issue;
    logic                  last_xfer;

    // pend marks a read whose data is on mem_rdata this cycle; it is presented
    // directly when the FIFO is empty so the first word appears without a bubble.
    assign held       = fill + {1'b0, pend};
    assign mem_ren    = (state == FETCH) && (held < 2'd2);
    assign mem_raddr  = mem_ren ? (base_q + issue_cnt[addressWidth:0]) : last_addr;
    assign head       = (fill == 2'd0) ? mem_rdata : q0;
    assign w_valid    = (fill != 2'd0) || pend;
    assign w_data     = w_valid ? head : '0;
    assign w_last     = w_valid && (xfer_cnt == LAST_IDX);
    assign pop        = w_valid && w_ready;
    assign last_issue = mem_ren && (issue_cnt == LAST_IDX);
    assign last_xfer  = pop && (xfer_cnt == LAST_IDX);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            issue_cnt <= '0;
            xfer_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && last_xfer;
            if (mem_ren)
                issue_cnt <= issue_cnt + CW'(1);
            if (pop)
                xfer_cnt <= xfer_cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        base_q    <= base_addr;
                        issue_cnt <= '0;
                        xfer_cnt  <= '0;
                    end
                end
                FETCH: begin
                    if (last_issue)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (last_xfer)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_addr <= '0;
        else if (mem_ren)
            last_addr <= mem_raddr;
    end

    // Occupancy never exceeds 2: a read is only issued while held < 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= 2'd0;
            pend <= 1'b0;
            q0   <= '0;
            q1   <= '0;
        end else begin
            pend <= mem_ren;
            case ({pop, pend})
                2'b01: begin
                    if (fill == 2'd0)
                        q0 <= mem_rdata;
                    else
                        q1 <= mem_rdata;
                    fill <= fill + 2'd1;
                end
                2'b10: begin
                    q0   <= q1;
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    // with fill == 0 the arriving word leaves straight through
                    if (fill == 2'd1) begin
                        q0 <= mem_rdata;
                    end else if (fill == 2'd2) begin
                        q0 <= q1;
                        q1 <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: table-driven runs, random runs against a
// word-stream model, and hand sequences for reset abort and numWeight=1.
module tb_weight_fetch_ctrl;
    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct {
        logic [AW:0]      base;
        int               mode;        // 0 ready high, 1 stall 5 cycles, 2 random
        int               restart_at;  // cycle of a second start pulse, -1 none
        logic [AW:0]      restart_base;
        logic [3:0][AW:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start, mem_ren, w_valid, w_ready, w_last, busy, done;
    logic [AW:0]   base_addr, mem_raddr;
    logic [DW-1:0] mem_rdata, w_data;

    logic          start1, ren1, wvalid1, wready1, wlast1, busy1, done1;
    logic [AW:0]   base1, raddr1;
    logic [DW-1:0] rdata1, wdata1;

    int checks = 0;
    int errors = 0;

    weight_fetch_ctrl #(.addressWidth(AW), .dataWidth(DW), .numWeight(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .busy(busy), .done(done)
    );

    weight_fetch_ctrl #(.addressWidth(AW), .dataWidth(DW), .numWeight(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base1),
        .mem_ren(ren1), .mem_raddr(raddr1), .mem_rdata(rdata1),
        .w_data(wdata1), .w_valid(wvalid1), .w_ready(wready1), .w_last(wlast1),
        .busy(busy1), .done(done1)
    );

    function automatic logic [DW-1:0] mdata(input logic [AW:0] a);
        return {a[4:0], a} ^ 16'hA5C3;
    endfunction

    // Synchronous memory: data one cycle after the read, junk otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? mdata(mem_raddr) : 16'($urandom);
        rdata1    <= ren1 ? mdata(raddr1) : 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; cycle 0 is the start-accept cycle.
    task automatic do_run(input vec_t v);
        int cyc, n_ren, n_xfer, first_ren, last_ren, first_val, last_xfer, low_left;
        bit seen, prev_stall, done_exp, finished;
        logic [DW-1:0] prev_data;
        cyc = 0; n_ren = 0; n_xfer = 0; first_ren = -1; last_ren = -1;
        first_val = -1; last_xfer = -1; low_left = 0;
        seen = 0; prev_stall = 0; done_exp = 0; finished = 0; prev_data = '0;
        start = 1'b1;
        base_addr = v.base;
        w_ready = (v.mode == 0);
        while (cyc < 80) begin
            @(negedge clk);
            done_exp = (n_xfer == 4) && (last_xfer == cyc - 1);
            chk("busy", 32'(busy), 32'((cyc >= 1) && (n_xfer < 4)));
            chk("done", 32'(done), 32'(done_exp));
            if (mem_ren) begin
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
                if (n_ren < 4) chk("raddr", 32'(mem_raddr), 32'(v.exp_addr[n_ren]));
                else chk("extra_read", n_ren, 3);
                n_ren++;
            end
            chk("outstanding_le2", 32'((n_ren - n_xfer) <= 2), 1);
            if (prev_stall) begin
                chk("hold_valid", 32'(w_valid), 1);
                chk("hold_data", 32'(w_data), 32'(prev_data));
            end
            if (w_valid) chk("wlast", 32'(w_last), 32'(n_xfer == 3));
            else chk("wlast_idle", 32'(w_last), 0);
            if (w_valid && first_val < 0) first_val = cyc;
            if (w_valid && !seen) begin
                seen = 1;
                low_left = 4;
            end
            if (w_valid && w_ready) begin
                if (n_xfer < 4) chk("wdata", 32'(w_data), 32'(mdata(v.exp_addr[n_xfer])));
                else chk("extra_xfer", n_xfer, 3);
                n_xfer++;
                last_xfer = cyc;
            end
            prev_stall = w_valid && !w_ready;
            prev_data = w_data;
            if (done_exp) begin
                finished = 1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == v.restart_at);
            base_addr = (cyc == v.restart_at) ? v.restart_base : 11'($urandom);
            case (v.mode)
                0: w_ready = 1'b1;
                1: begin
                    w_ready = seen && (low_left == 0);
                    if (low_left > 0) low_left--;
                end
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
        end
        chk("run_finished", 32'(finished), 1);
        chk("reads", n_ren, 4);
        chk("xfers", n_xfer, 4);
        chk("first_ren_cycle", first_ren, 1);
        chk("first_valid_cycle", first_val, 2);
        if (v.mode == 0) begin
            chk("last_ren_cycle", last_ren, 4);
            chk("last_xfer_cycle", last_xfer, 5);
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("tail_done", 32'(done), 0);
            chk("tail_busy", 32'(busy), 0);
            chk("tail_ren", 32'(mem_ren), 0);
            chk("tail_valid", 32'(w_valid), 0);
            chk("tail_raddr_hold", 32'(mem_raddr), 32'(v.exp_addr[3]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        vec_t rv;
        start = 0; base_addr = '0; w_ready = 0;
        start1 = 0; base1 = '0; wready1 = 1;

        tbl[0] = '{base: 11'h010, mode: 0, restart_at: -1, restart_base: 11'h000,
                   exp_addr: {11'h013, 11'h012, 11'h011, 11'h010}};
        tbl[1] = '{base: 11'h100, mode: 1, restart_at: -1, restart_base: 11'h000,
                   exp_addr: {11'h103, 11'h102, 11'h101, 11'h100}};
        tbl[2] = '{base: 11'h7FE, mode: 0, restart_at: -1, restart_base: 11'h000,
                   exp_addr: {11'h001, 11'h000, 11'h7FF, 11'h7FE}};
        tbl[3] = '{base: 11'h0A0, mode: 0, restart_at: 3, restart_base: 11'h555,
                   exp_addr: {11'h0A3, 11'h0A2, 11'h0A1, 11'h0A0}};
        tbl[4] = '{base: 11'h7FF, mode: 1, restart_at: 2, restart_base: 11'h3C0,
                   exp_addr: {11'h002, 11'h001, 11'h000, 11'h7FF}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ren", 32'(mem_ren), 0);
        chk("rst_raddr", 32'(mem_raddr), 0);
        chk("rst_valid", 32'(w_valid), 0);
        chk("rst_wdata", 32'(w_data), 0);
        chk("rst_wlast", 32'(w_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst1_busy", 32'(busy1), 0);
        @(posedge clk);
        #1;
        rst = 0;
        do_run(tbl[0]);
        for (int i = 1; i < 5; i++) begin
            @(posedge clk);
            #1;
            do_run(tbl[i]);
        end

        // reset after the second transfer, then a fresh run from a new base
        @(posedge clk);
        #1;
        start = 1; base_addr = 11'h200; w_ready = 1;
        @(posedge clk);
        #1;
        start = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_w0", 32'(w_data), 32'(mdata(11'h200)));
        @(posedge clk);
        @(negedge clk);
        chk("abort_w1", 32'(w_data), 32'(mdata(11'h201)));
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("abort_ren", 32'(mem_ren), 0);
        chk("abort_raddr", 32'(mem_raddr), 0);
        chk("abort_valid", 32'(w_valid), 0);
        chk("abort_wdata", 32'(w_data), 0);
        chk("abort_wlast", 32'(w_last), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        chk("abort_inflight_dropped", 32'(w_valid), 0);
        @(posedge clk);
        #1;
        rst = 0;
        rv = '{base: 11'h055, mode: 0, restart_at: -1, restart_base: 11'h000,
               exp_addr: {11'h058, 11'h057, 11'h056, 11'h055}};
        do_run(rv);

        for (int r = 0; r < 9; r++) begin
            rv.base = 11'($urandom);
            rv.mode = r % 3;
            rv.restart_at = (r % 2 == 1) ? int'($urandom_range(1, 4)) : -1;
            rv.restart_base = 11'($urandom);
            for (int k = 0; k < 4; k++) rv.exp_addr[k] = rv.base + 11'(k);
            @(posedge clk);
            #1;
            do_run(rv);
        end

        // numWeight = 1 with a back-to-back start in the done cycle
        @(posedge clk);
        #1;
        start1 = 1; base1 = 11'h3A0;
        @(negedge clk);
        chk("n1_c0_busy", 32'(busy1), 0);
        @(posedge clk);
        #1;
        start1 = 0; base1 = 11'h111;
        @(negedge clk);
        chk("n1_c1_ren", 32'(ren1), 1);
        chk("n1_c1_raddr", 32'(raddr1), 32'(11'h3A0));
        chk("n1_c1_busy", 32'(busy1), 1);
        chk("n1_c1_valid", 32'(wvalid1), 0);
        @(negedge clk);
        chk("n1_c2_valid", 32'(wvalid1), 1);
        chk("n1_c2_wdata", 32'(wdata1), 32'(mdata(11'h3A0)));
        chk("n1_c2_wlast", 32'(wlast1), 1);
        chk("n1_c2_ren", 32'(ren1), 0);
        @(posedge clk);
        #1;
        start1 = 1; base1 = 11'h3A5;
        @(negedge clk);
        chk("n1_c3_done", 32'(done1), 1);
        chk("n1_c3_busy", 32'(busy1), 0);
        chk("n1_c3_valid", 32'(wvalid1), 0);
        @(posedge clk);
        #1;
        start1 = 0; base1 = 11'h222;
        @(negedge clk);
        chk("n1_c4_ren", 32'(ren1), 1);
        chk("n1_c4_raddr", 32'(raddr1), 32'(11'h3A5));
        chk("n1_c4_done", 32'(done1), 0);
        @(negedge clk);
        chk("n1_c5_wdata", 32'(wdata1), 32'(mdata(11'h3A5)));
        chk("n1_c5_wlast", 32'(wlast1), 1);
        @(negedge clk);
        chk("n1_c6_done", 32'(done1), 1);
        @(negedge clk);
        chk("n1_c7_done", 32'(done1), 0);
        chk("n1_c7_raddr_hold", 32'(raddr1), 32'(11'h3A5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
